// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clk_en_gen NCO clock-enable generator.
package clk_en_gen_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    ALIGN  = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } cg_state_e;

  typedef enum logic [1:0] {
    NCO_HOLD  = 2'd0,
    NCO_RUN   = 2'd1,
    NCO_CLEAR = 2'd2
  } nco_ctrl_e;

  // Settle counter must hold values up to LOCK_CYCLES.
  function automatic int settle_cnt_w(input int lock_cycles);
    return (lock_cycles < 1) ? 1 : $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_en_gen_nco_acc.sv
// Single-channel NCO phase accumulator with run/clear/hold control.
// The wrap carry is registered together with the accumulator.
module clk_en_gen_nco_acc
  import clk_en_gen_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  nco_ctrl_e        i_ctrl,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_carry,
  output logic             o_msb
);

  logic [ACC_W-1:0] r_acc;
  logic             r_carry;
  logic [ACC_W:0]   w_sum;

  // Widened sum so the modulo-2^ACC_W wrap shows up as the top bit
  always_comb begin
    w_sum = {1'b0, r_acc} + {1'b0, i_inc};
  end

  // Phase accumulator register: advance, clear for realignment, or hold
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc   <= {ACC_W{1'b0}};
      r_carry <= 1'b0;
    end else begin
      case (i_ctrl)
        NCO_RUN: begin
          r_acc   <= w_sum[ACC_W-1:0];
          r_carry <= w_sum[ACC_W];
        end
        NCO_CLEAR: begin
          r_acc   <= {ACC_W{1'b0}};
          r_carry <= 1'b0;
        end
        default: begin
          r_acc   <= r_acc;
          r_carry <= 1'b0;
        end
      endcase
    end
  end

  assign o_carry = r_carry;
  assign o_msb   = r_acc[ACC_W-1];

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel runtime-programmable clock-enable generator built from NCO
// accumulators; commits realign every channel and re-run a settle period.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INC_DEFAULT = {NUM_CH{{2'b01, {(ACC_W-2){1'b0}}}}},
  localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_commit,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] ph,
  output logic              locked
);

  localparam int CNT_W = settle_cnt_w(LOCK_CYCLES);

  cg_state_e         r_state;
  cg_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  nco_ctrl_e         w_ctrl;
  logic              w_run_now;
  logic              w_run_nxt;
  logic              w_wr_en;
  logic [ACC_W-1:0]  r_shadow [NUM_CH];
  logic [ACC_W-1:0]  r_active [NUM_CH];
  logic [NUM_CH-1:0] w_carry;
  logic [NUM_CH-1:0] w_msb;
  logic              r_ready;
  logic              r_locked;
  logic [NUM_CH-1:0] r_ce;
  logic [NUM_CH-1:0] r_ph;

  // Next-state, settle counter and accumulator control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ctrl      = NCO_HOLD;
    case (r_state)
      RESET: begin
        w_state_nxt = ALIGN;
      end
      ALIGN: begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_ctrl      = NCO_CLEAR;
      end
      SETTLE: begin
        w_ctrl    = NCO_RUN;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (cfg_commit) begin
          w_state_nxt = ALIGN;
        end else if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          w_state_nxt = LOCKED;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      LOCKED: begin
        w_ctrl = NCO_RUN;
        if (cfg_commit) begin
          w_state_nxt = ALIGN;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: begin
        w_state_nxt = RESET;
      end
    endcase
  end

  // Run-state decodes and write acceptance
  always_comb begin
    w_run_now = (r_state == SETTLE) || (r_state == LOCKED);
    w_run_nxt = (w_state_nxt == SETTLE) || (w_state_nxt == LOCKED);
    w_wr_en   = cfg_valid && r_ready;
  end

  // FSM state, settle counter and registered status/strobe outputs
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state  <= RESET;
      r_cnt    <= {CNT_W{1'b0}};
      r_ready  <= 1'b0;
      r_locked <= 1'b0;
      r_ce     <= {NUM_CH{1'b0}};
      r_ph     <= {NUM_CH{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ready  <= w_run_nxt;
      r_locked <= (w_state_nxt == LOCKED);
      // Gate on the next state too so a commit never leaves a stray pulse
      r_ce     <= w_carry & {NUM_CH{(r_state == LOCKED) && (w_state_nxt == LOCKED)}};
      r_ph     <= w_msb & {NUM_CH{w_run_now && w_run_nxt}};
    end
  end

  // Shadow increments take writes; active increments load only on ALIGN
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= INC_DEFAULT[i*ACC_W +: ACC_W];
        r_active[i] <= INC_DEFAULT[i*ACC_W +: ACC_W];
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_en && (int'(cfg_ch) == i)) begin
          r_shadow[i] <= cfg_inc;
        end
        if (r_state == ALIGN) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_gen_nco_acc #(
      .ACC_W (ACC_W)
    ) u_nco (
      .i_clk   (refclk),
      .i_rst_n (rst_n),
      .i_ctrl  (w_ctrl),
      .i_inc   (r_active[g]),
      .o_carry (w_carry[g]),
      .o_msb   (w_msb[g])
    );
  end

  assign cfg_ready = r_ready;
  assign locked    = r_locked;
  assign ce        = r_ce;
  assign ph        = r_ph;

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: closed-form NCO reference model checked
// every cycle, a table of configuration scenarios, and directed corner cases.
module tb_clk_en_gen;

  localparam int NCH = 3;
  localparam int W   = 32;
  localparam int L   = 16;
  localparam logic [W-1:0] DEF_INC = 32'h4000_0000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           valid;
  logic           ready;
  logic [1:0]     ch;
  logic [W-1:0]   inc;
  logic           commit;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] ph;
  logic           locked;

  clk_en_gen #(
    .NUM_CH      (NCH),
    .ACC_W       (W),
    .LOCK_CYCLES (L),
    .INC_DEFAULT ({NCH{DEF_INC}})
  ) dut (
    .refclk     (clk),
    .rst_n      (rst_n),
    .cfg_valid  (valid),
    .cfg_ready  (ready),
    .cfg_ch     (ch),
    .cfg_inc    (inc),
    .cfg_commit (commit),
    .ce         (ce),
    .ph         (ph),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: m_n counts accumulator steps since the last realignment
  // (-2 right after reset, -1 while the realignment cycle is pending).
  int             m_n;
  logic [W-1:0]   m_shadow [NCH];
  logic [W-1:0]   m_active [NCH];
  logic [NCH-1:0] m_ce, m_ph;
  logic           m_locked, m_ready;

  int last_ce [NCH];
  int prev_ce [NCH];

  function automatic logic msb_after(input longint unsigned k, input logic [W-1:0] f);
    longint unsigned p;
    p = k * f;
    return p[W-1];
  endfunction

  // True when phase k*f has crossed a multiple of 2^W since step k-1
  function automatic logic wrapped_at(input longint unsigned k, input logic [W-1:0] f);
    longint unsigned a, b;
    a = k * f;
    b = (k - 1) * f;
    return (a >> W) != (b >> W);
  endfunction

  task automatic model_edge();
    bit was_run;
    was_run = (m_n >= 0);
    if (!rst_n) begin
      m_n = -2;
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = DEF_INC;
        m_active[i] = DEF_INC;
      end
    end else begin
      if (was_run && valid && (int'(ch) < NCH)) m_shadow[ch] = inc;
      if (was_run && commit) begin
        m_n = -1;
      end else begin
        m_n = m_n + 1;
        if (m_n == 0) m_active = m_shadow;
      end
    end
    m_ready  = (m_n >= 0);
    m_locked = (m_n >= L);
    for (int i = 0; i < NCH; i++) begin
      m_ph[i] = (m_n >= 1)     ? msb_after(longint'(m_n - 1), m_active[i]) : 1'b0;
      m_ce[i] = (m_n >= L + 1) ? wrapped_at(longint'(m_n - 1), m_active[i]) : 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("ce", 32'(ce), 32'(m_ce));
    chk("ph", 32'(ph), 32'(m_ph));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("ready", 32'(ready), 32'(m_ready));
    for (int i = 0; i < NCH; i++) begin
      if (ce[i]) begin
        prev_ce[i] = last_ce[i];
        last_ce[i] = cyc;
      end
    end
  endtask

  task automatic idle_inputs();
    rst_n  = 1'b1;
    valid  = 1'b0;
    ch     = 2'd0;
    inc    = 32'h0;
    commit = 1'b0;
  endtask

  task automatic clear_periods();
    for (int i = 0; i < NCH; i++) begin
      last_ce[i] = -1;
      prev_ce[i] = -1;
    end
  endtask

  function automatic int period_of(input int i);
    return (prev_ce[i] >= 0) ? (last_ce[i] - prev_ce[i]) : 0;
  endfunction

  typedef struct {
    bit         rst_n;
    bit         valid;
    logic [1:0] ch;
    logic [W-1:0] inc;
    bit         commit;
    int         idle;
    int         p0, p1, p2;
    bit         lck;
  } row_t;

  row_t tbl [9];

  initial begin
    int cnt;
    int bad_ce;

    tbl[0] = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 40, 4, 4, 4, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 2'd1, 32'h8000_0000, 1'b0, 12, 4, 4, 4, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b1, 40, 4, 2, 4, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 2'd0, 32'h0,         1'b1, 40, 0, 2, 4, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 2'd3, 32'h1000_0000, 1'b0, 12, 0, 2, 4, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b1, 40, 0, 2, 4, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b1, 40, 0, 2, 1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 40, 4, 4, 4, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 2'd1, 32'h2000_0000, 1'b1, 50, 4, 8, 4, 1'b1};

    m_n = -2;
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = DEF_INC;
      m_active[i] = DEF_INC;
    end
    clear_periods();
    idle_inputs();

    // Reset values and lock latency after release
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    rst_n = 1'b1;
    cnt = 0;
    while (!locked && cnt < 100) begin
      step();
      cnt++;
    end
    chk("lock_latency", cnt, 32'(2 + L));

    // Configuration scenarios with expected ce periods
    for (int r = 0; r < 9; r++) begin
      rst_n  = tbl[r].rst_n;
      valid  = tbl[r].valid;
      ch     = tbl[r].ch;
      inc    = tbl[r].inc;
      commit = tbl[r].commit;
      step();
      idle_inputs();
      clear_periods();
      repeat (tbl[r].idle) step();
      chk($sformatf("row%0d_per0", r), period_of(0), tbl[r].p0);
      chk($sformatf("row%0d_per1", r), period_of(1), tbl[r].p1);
      chk($sformatf("row%0d_per2", r), period_of(2), tbl[r].p2);
      chk($sformatf("row%0d_lock", r), 32'(locked), 32'(tbl[r].lck));
    end

    // Commit with the settle counter at 10, then a full settle again
    commit = 1'b1;
    step();
    commit = 1'b0;
    repeat (11) step();
    chk("settle10_unlocked", 32'(locked), 32'h0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("align_ready", 32'(ready), 32'h0);
    cnt = 1;
    bad_ce = 0;
    while (!locked && cnt < 100) begin
      step();
      cnt++;
      if (!locked && ce != 3'b000) bad_ce++;
    end
    chk("relock_latency", cnt, 32'(2 + L));
    chk("ce_while_unlocked", bad_ce, 0);

    // One-cycle reset while locked
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst1_ce", 32'(ce), 32'h0);
    chk("rst1_ph", 32'(ph), 32'h0);
    chk("rst1_locked", 32'(locked), 32'h0);
    chk("rst1_ready", 32'(ready), 32'h0);
    step();
    chk("rst1_align_ready", 32'(ready), 32'h0);
    step();
    chk("rst1_settle_ready", 32'(ready), 32'h1);

    // Randomized traffic against the reference model
    for (int k = 0; k < 2500; k++) begin
      valid  = ($urandom_range(3) == 0);
      ch     = 2'($urandom_range(3));
      case ($urandom_range(4))
        0:       inc = 32'h0;
        1:       inc = 32'hFFFF_FFFF;
        2:       inc = 32'($urandom);
        3:       inc = 32'h1 << $urandom_range(31);
        default: inc = 32'($urandom) >> 8;
      endcase
      commit = ($urandom_range(59) == 0);
      rst_n  = ($urandom_range(399) != 0);
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
